// File: rtl/axis_master_pkt_gen.sv
// rtl/axis_master_pkt_gen.sv - AXI-Stream packet generator emitting incrementing-data packets with optional inter-beat gaps
module axis_master_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   cmd_seed,
  input  logic [DEST_WIDTH-1:0]   cmd_dest,
  input  logic [GAP_WIDTH-1:0]    cmd_gap,
  output logic                    tvalid,
  input  logic                    tready,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tstrb,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic                    tlast,
  output logic                    tid,
  output logic [DEST_WIDTH-1:0]   tdest,
  output logic [USER_WIDTH-1:0]   tuser,
  output logic [15:0]             pkt_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_cmd_ready;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [GAP_WIDTH-1:0]  r_gap;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [15:0]           r_pkt_count;

  logic w_cmd_fire;
  logic w_beat_fire;
  logic w_is_last;
  logic w_tvalid;
  logic w_first;

  // cmd_ready is a register that is only high in IDLE, so it alone qualifies the command handshake
  assign w_cmd_fire  = cmd_valid & r_cmd_ready;
  assign w_is_last   = (r_beat == r_len);
  assign w_beat_fire = w_tvalid & tready;

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_fire) w_next_state = S_SEND;
      S_SEND: begin
        if (w_beat_fire) begin
          if (w_is_last)           w_next_state = S_IDLE;
          else if (r_gap != '0)    w_next_state = S_GAP;
          else                     w_next_state = S_SEND;
        end
      end
      S_GAP:  if (r_gap_cnt == '0) w_next_state = S_SEND;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: valid/last/first are pure functions of registered state, never of tready
  always_comb begin
    w_tvalid = (r_state == S_SEND);
    w_first  = w_tvalid & (r_beat == '0);
    tlast    = w_tvalid & w_is_last;
    tuser    = '0;
    tuser[0] = w_first;
  end

  // Command latch, beat/data advance, gap countdown and packet counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cmd_ready <= 1'b0;
      r_len       <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_data      <= '0;
      r_dest      <= '0;
      r_pkt_count <= '0;
    end else begin
      r_cmd_ready <= (w_next_state == S_IDLE);
      if (w_cmd_fire) begin
        r_len  <= cmd_len;
        r_data <= cmd_seed;
        r_dest <= cmd_dest;
        r_gap  <= cmd_gap;
        r_beat <= '0;
      end else if (w_beat_fire && !w_is_last) begin
        r_data <= r_data + DATA_WIDTH'(1);
        r_beat <= r_beat + LEN_WIDTH'(1);
      end
      // Loaded with gap-1 so GAP lasts exactly r_gap cycles before returning to SEND
      if (w_beat_fire && !w_is_last && (r_gap != '0))
        r_gap_cnt <= r_gap - GAP_WIDTH'(1);
      else if ((r_state == S_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
      if (w_beat_fire && w_is_last)
        r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign tvalid    = w_tvalid;
  assign tdata     = r_data;
  assign tdest     = r_dest;
  assign tstrb     = '1;
  assign tkeep     = '1;
  assign tid       = 1'b0;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_master_pkt_gen.sv
// tb/tb_axis_master_pkt_gen.sv - directed self-checking bench for axis_master_pkt_gen
module tb_axis_master_pkt_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [31:0] cmd_seed;
  logic [3:0]  cmd_dest;
  logic [7:0]  cmd_gap;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tid;
  logic [3:0]  tdest;
  logic [0:0]  tuser;
  logic [15:0] pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_data [64];
  logic        cap_last [64];
  logic        cap_user [64];
  logic [3:0]  cap_dest [64];
  int          cap_cyc  [64];
  int          cap_n;
  int          stall_err;
  int          valid_cycles;
  logic [31:0] exp_data [4];

  axis_master_pkt_gen dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_seed(cmd_seed), .cmd_dest(cmd_dest), .cmd_gap(cmd_gap),
    .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
    .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
    .tuser(tuser), .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] seed, input logic [15:0] len,
                          input logic [3:0] dest, input logic [7:0] gap);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      step();
      w++;
    end
    n_tests++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%0b required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_seed  = seed;
    cmd_len   = len;
    cmd_dest  = dest;
    cmd_gap   = gap;
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (tvalid !== 1'b1 || tdata !== seed || tuser[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_beat_latency: tvalid=%0b tdata=%h tuser=%0b required 1 %h 1",
               tvalid, tdata, tuser[0], seed);
    end
  endtask

  // mode 0: tready held high; mode 1: tready 1,0,1,0...
  task automatic collect(input int mode, input int max_cyc);
    logic        have_prev;
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_user;
    logic        done;
    cap_n = 0;
    stall_err = 0;
    valid_cycles = 0;
    have_prev = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    prev_user = 1'b0;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      tready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (have_prev && (tvalid !== 1'b1 || tdata !== prev_data ||
                        tlast !== prev_last || tuser[0] !== prev_user))
        stall_err++;
      have_prev = 1'b0;
      if (tvalid) valid_cycles++;
      if (tvalid && tready) begin
        if (cap_n < 64) begin
          cap_data[cap_n] = tdata;
          cap_last[cap_n] = tlast;
          cap_user[cap_n] = tuser[0];
          cap_dest[cap_n] = tdest;
          cap_cyc[cap_n]  = c;
        end
        cap_n++;
        if (tlast) done = 1'b1;
      end else if (tvalid) begin
        have_prev = 1'b1;
        prev_data = tdata;
        prev_last = tlast;
        prev_user = tuser[0];
      end
      step();
    end
    tready = 1'b1;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL collect_timeout: last beat not seen, beats=%0d required tlast within %0d cycles",
               cap_n, max_cyc);
    end
  endtask

  task automatic check_end(input logic [15:0] exp_count);
    n_tests++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || cmd_ready !== 1'b1 || pkt_count !== exp_count) begin
      n_fail++;
      $display("FAIL packet_end: tvalid=%0b tlast=%0b cmd_ready=%0b pkt_count=%0d required 0 0 1 %0d",
               tvalid, tlast, cmd_ready, pkt_count, exp_count);
    end
  endtask

  task automatic check_beats(input string name, input int n);
    int bad;
    bad = 0;
    n_tests++;
    if (cap_n != n) bad++;
    for (int k = 0; k < n && k < cap_n; k++)
      if (cap_data[k] !== exp_data[k] || cap_last[k] !== (k == n - 1) || cap_user[k] !== (k == 0))
        bad++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: beats=%0d errors=%0d first=%h last=%h required %0d beats %h..%h",
               name, cap_n, bad, cap_data[0], cap_data[(cap_n > 0) ? cap_n - 1 : 0],
               n, exp_data[0], exp_data[n-1]);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    step();
    step();
    n_tests++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'h0 || tdest !== 4'h0 ||
        tuser !== 1'b0 || cmd_ready !== 1'b0 || pkt_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: tvalid=%0b tlast=%0b tdata=%h tdest=%h tuser=%0b cmd_ready=%0b cnt=%0d required all 0",
               tvalid, tlast, tdata, tdest, tuser, cmd_ready, pkt_count);
    end
    aresetn = 1'b1;
    step();
    n_tests++;
    if (cmd_ready !== 1'b1 || tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%0b tvalid=%0b required 1 0", cmd_ready, tvalid);
    end
    n_tests++;
    if (tstrb !== 4'hF || tkeep !== 4'hF || tid !== 1'b0) begin
      n_fail++;
      $display("FAIL constants: tstrb=%h tkeep=%h tid=%0b required F F 0", tstrb, tkeep, tid);
    end
  endtask

  task automatic test_basic();
    send_cmd(32'h10, 16'd3, 4'h2, 8'd0);
    collect(0, 20);
    exp_data[0] = 32'h10; exp_data[1] = 32'h11; exp_data[2] = 32'h12; exp_data[3] = 32'h13;
    check_beats("basic_beats", 4);
    n_tests++;
    if (cap_cyc[0] != 0 || cap_cyc[1] != 1 || cap_cyc[2] != 2 || cap_cyc[3] != 3) begin
      n_fail++;
      $display("FAIL basic_back_to_back: cycles %0d %0d %0d %0d required 0 1 2 3",
               cap_cyc[0], cap_cyc[1], cap_cyc[2], cap_cyc[3]);
    end
    check_end(16'd1);
  endtask

  task automatic test_backpressure();
    send_cmd(32'h10, 16'd3, 4'h2, 8'd0);
    collect(1, 30);
    check_beats("stall_beats", 4);
    n_tests++;
    if (stall_err != 0 || cap_cyc[3] != 6) begin
      n_fail++;
      $display("FAIL stall_stable: unstable_cycles=%0d last_cycle=%0d required 0 6", stall_err, cap_cyc[3]);
    end
    check_end(16'd2);
  endtask

  task automatic test_gap();
    send_cmd(32'hA0, 16'd2, 4'h1, 8'd3);
    collect(0, 30);
    exp_data[0] = 32'hA0; exp_data[1] = 32'hA1; exp_data[2] = 32'hA2;
    check_beats("gap_beats", 3);
    n_tests++;
    if (cap_cyc[0] != 0 || cap_cyc[1] != 4 || cap_cyc[2] != 8 || valid_cycles != 3) begin
      n_fail++;
      $display("FAIL gap_timing: cycles %0d %0d %0d valid=%0d required 0 4 8 valid=3",
               cap_cyc[0], cap_cyc[1], cap_cyc[2], valid_cycles);
    end
    check_end(16'd3);
  endtask

  task automatic test_wrap();
    send_cmd(32'hFFFFFFFE, 16'd3, 4'h0, 8'd0);
    collect(0, 20);
    exp_data[0] = 32'hFFFFFFFE; exp_data[1] = 32'hFFFFFFFF;
    exp_data[2] = 32'h00000000; exp_data[3] = 32'h00000001;
    check_beats("wrap_beats", 4);
    check_end(16'd4);
  endtask

  task automatic test_single_hold();
    int bad;
    tready = 1'b0;
    send_cmd(32'hAB, 16'd0, 4'd5, 8'd0);
    // Keep a different command asserted while the packet is in flight
    cmd_valid = 1'b1;
    cmd_seed  = 32'h55;
    cmd_len   = 16'd1;
    cmd_dest  = 4'd9;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_ready !== 1'b0 || tvalid !== 1'b1 || tdata !== 32'hAB || tdest !== 4'd5) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL cmd_ignored: errors=%0d tdata=%h tdest=%0d cmd_ready=%0b required AB 5 0",
               bad, tdata, tdest, cmd_ready);
    end
    collect(0, 10);
    cmd_valid = 1'b0;
    exp_data[0] = 32'hAB;
    check_beats("single_beat", 1);
    n_tests++;
    if (cap_dest[0] !== 4'd5) begin
      n_fail++;
      $display("FAIL single_dest: tdest=%0d required 5", cap_dest[0]);
    end
    check_end(16'd5);
  endtask

  task automatic test_reset_mid();
    int bad;
    send_cmd(32'h0, 16'd7, 4'h3, 8'd0);
    tready = 1'b1;
    step();
    step();
    n_tests++;
    if (tvalid !== 1'b1 || tdata !== 32'h2) begin
      n_fail++;
      $display("FAIL mid_beat2: tvalid=%0b tdata=%h required 1 00000002", tvalid, tdata);
    end
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    n_tests++;
    if (tvalid !== 1'b0 || pkt_count !== 16'd0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: tvalid=%0b pkt_count=%0d cmd_ready=%0b required 0 0 0",
               tvalid, pkt_count, cmd_ready);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tvalid !== 1'b0 || cmd_ready !== 1'b1 || pkt_count !== 16'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL after_abort: errors=%0d tvalid=%0b cmd_ready=%0b pkt_count=%0d required 0 1 0",
               bad, tvalid, cmd_ready, pkt_count);
    end
  endtask

  initial begin
    aresetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_seed  = '0;
    cmd_dest  = '0;
    cmd_gap   = '0;
    tready    = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_wrap();
    test_single_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
